// File: rtl/toy_bus_arb_node_req_rr_lock.sv
// 2:1 round-robin request merge with a registered output stage.
// A sideband bit can hold the grant on one requester, bounded by LOCK_MAX beats.
module toy_bus_arb_node_req_rr_lock #(
    parameter int LOCK_BIT = 9,
    parameter int LOCK_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in0_vld,
    output logic         in0_rdy,
    input  logic [31:0]  in0_addr,
    input  logic [31:0]  in0_strb,
    input  logic [255:0] in0_data,
    input  logic         in0_opcode,
    input  logic [3:0]   in0_src_id,
    input  logic [3:0]   in0_tgt_id,
    input  logic [9:0]   in0_sideband,
    input  logic         in1_vld,
    output logic         in1_rdy,
    input  logic [31:0]  in1_addr,
    input  logic [31:0]  in1_strb,
    input  logic [255:0] in1_data,
    input  logic         in1_opcode,
    input  logic [3:0]   in1_src_id,
    input  logic [3:0]   in1_tgt_id,
    input  logic [9:0]   in1_sideband,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [31:0]  out_addr,
    output logic [31:0]  out_strb,
    output logic [255:0] out_data,
    output logic         out_opcode,
    output logic [3:0]   out_src_id,
    output logic [3:0]   out_tgt_id,
    output logic [9:0]   out_sideband,
    output logic         lock_timeout
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t      state, state_next;
    logic        lock_owner, lock_owner_next;
    logic [7:0]  lock_cnt, lock_cnt_next;
    logic        rr_last, rr_last_next;
    logic        lock_timeout_next;
    logic [1:0]  grant;
    logic        pipe_free;
    logic        load;
    logic        sel;
    logic        sel_lock;

    assign pipe_free = !out_vld || out_rdy;
    assign load      = pipe_free && (|grant);
    assign in0_rdy   = grant[0] && pipe_free;
    assign in1_rdy   = grant[1] && pipe_free;
    assign sel       = grant[1];
    assign sel_lock  = sel ? in1_sideband[LOCK_BIT] : in0_sideband[LOCK_BIT];

    // While locked, the non-owner is shut out even if the owner is idle.
    always_comb begin
        grant = 2'b00;
        if (state == LOCKED) begin
            if (lock_owner) grant[1] = in1_vld;
            else            grant[0] = in0_vld;
        end else if (in0_vld && in1_vld) begin
            if (rr_last) grant[0] = 1'b1;
            else         grant[1] = 1'b1;
        end else begin
            grant = {in1_vld, in0_vld};
        end
    end

    always_comb begin
        state_next        = state;
        lock_owner_next   = lock_owner;
        lock_cnt_next     = lock_cnt;
        rr_last_next      = rr_last;
        lock_timeout_next = 1'b0;
        if (load) begin
            rr_last_next = sel;
            case (state)
                IDLE: begin
                    if (sel_lock) begin
                        if (LOCK_MAX > 1) begin
                            state_next      = LOCKED;
                            lock_owner_next = sel;
                            lock_cnt_next   = 8'd1;
                        end else begin
                            lock_timeout_next = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!sel_lock) begin
                        state_next    = IDLE;
                        lock_cnt_next = 8'd0;
                    end else if (({1'b0, lock_cnt} + 9'd1) < 9'(LOCK_MAX)) begin
                        lock_cnt_next = lock_cnt + 8'd1;
                    end else begin
                        state_next        = IDLE;
                        lock_cnt_next     = 8'd0;
                        lock_timeout_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lock_owner   <= 1'b0;
            lock_cnt     <= 8'd0;
            rr_last      <= 1'b1;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_next;
            lock_owner   <= lock_owner_next;
            lock_cnt     <= lock_cnt_next;
            rr_last      <= rr_last_next;
            lock_timeout <= lock_timeout_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld      <= 1'b0;
            out_addr     <= '0;
            out_strb     <= '0;
            out_data     <= '0;
            out_opcode   <= 1'b0;
            out_src_id   <= '0;
            out_tgt_id   <= '0;
            out_sideband <= '0;
        end else if (load) begin
            out_vld      <= 1'b1;
            out_addr     <= sel ? in1_addr     : in0_addr;
            out_strb     <= sel ? in1_strb     : in0_strb;
            out_data     <= sel ? in1_data     : in0_data;
            out_opcode   <= sel ? in1_opcode   : in0_opcode;
            out_src_id   <= sel ? in1_src_id   : in0_src_id;
            out_tgt_id   <= sel ? in1_tgt_id   : in0_tgt_id;
            out_sideband <= sel ? in1_sideband : in0_sideband;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toy_bus_arb_node_req_rr_lock.sv
// Randomized bench: a per-cycle behavioural arbiter model pushes expected beats to a
// scoreboard queue; an independent monitor checks every presented output beat.
module tb_toy_bus_arb_node_req_rr_lock;

    localparam int LOCK_MAX = 8;

    typedef struct packed {
        logic [31:0]  addr;
        logic [31:0]  strb;
        logic [255:0] data;
        logic         opcode;
        logic [3:0]   src;
        logic [3:0]   tgt;
        logic [9:0]   sb;
    } beat_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   in0_vld = 1'b0, in1_vld = 1'b0, out_rdy = 1'b0;
    beat_t  b0 = '0, b1 = '0;
    logic   in0_rdy, in1_rdy, out_vld, lock_timeout;
    beat_t  ob;

    int     checks = 0;
    int     errors = 0;
    beat_t  sb_q[$];

    // Reference model state
    int     m_occ, m_last, m_locked, m_owner, m_cnt, m_to_pending;

    always #5 clk = ~clk;

    toy_bus_arb_node_req_rr_lock #(.LOCK_BIT(9), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy),
        .in0_addr(b0.addr), .in0_strb(b0.strb), .in0_data(b0.data), .in0_opcode(b0.opcode),
        .in0_src_id(b0.src), .in0_tgt_id(b0.tgt), .in0_sideband(b0.sb),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy),
        .in1_addr(b1.addr), .in1_strb(b1.strb), .in1_data(b1.data), .in1_opcode(b1.opcode),
        .in1_src_id(b1.src), .in1_tgt_id(b1.tgt), .in1_sideband(b1.sb),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_addr(ob.addr), .out_strb(ob.strb), .out_data(ob.data), .out_opcode(ob.opcode),
        .out_src_id(ob.src), .out_tgt_id(ob.tgt), .out_sideband(ob.sb),
        .lock_timeout(lock_timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t rand_beat(input int id, input int lock_pct);
        beat_t b;
        b.addr = $urandom;
        b.strb = $urandom;
        for (int i = 0; i < 8; i++) b.data[i*32 +: 32] = $urandom;
        b.opcode = 1'($urandom);
        b.src = 4'(id * 4 + int'($urandom_range(0, 3)));
        b.tgt = 4'($urandom);
        b.sb = 10'($urandom);
        b.sb[9] = ($urandom_range(0, 99) < lock_pct);
        return b;
    endfunction

    task automatic model_reset();
        m_occ = 0; m_last = 1; m_locked = 0; m_owner = 0; m_cnt = 0; m_to_pending = 0;
    endtask

    // One clock: drive random inputs, predict who is accepted, check handshake and push.
    task automatic step(input int vld_pct, input int lock_pct, input int rdy_pct);
        int winner, free, lb, exp_r0, exp_r1;
        beat_t wb;
        @(negedge clk);
        in0_vld = ($urandom_range(0, 99) < vld_pct);
        in1_vld = ($urandom_range(0, 99) < vld_pct);
        b0 = rand_beat(0, lock_pct);
        b1 = rand_beat(1, lock_pct);
        out_rdy = ($urandom_range(0, 99) < rdy_pct);
        #1;
        check("out_vld", 64'(out_vld), 64'(m_occ));
        check("lock_timeout", 64'(lock_timeout), 64'(m_to_pending));
        m_to_pending = 0;
        winner = -1;
        if (m_locked != 0) begin
            if (m_owner == 0 && in0_vld) winner = 0;
            if (m_owner == 1 && in1_vld) winner = 1;
        end else if (in0_vld && in1_vld) winner = 1 - m_last;
        else if (in0_vld) winner = 0;
        else if (in1_vld) winner = 1;
        free = (m_occ == 0 || out_rdy) ? 1 : 0;
        if (free == 0) winner = -1;
        exp_r0 = (winner == 0) ? 1 : 0;
        exp_r1 = (winner == 1) ? 1 : 0;
        check("in0_rdy", 64'(in0_rdy), 64'(exp_r0));
        check("in1_rdy", 64'(in1_rdy), 64'(exp_r1));
        if (winner >= 0) begin
            wb = (winner == 1) ? b1 : b0;
            sb_q.push_back(wb);
            lb = int'(wb.sb[9]);
            m_last = winner;
            m_occ = 1;
            if (m_locked == 0) begin
                if (lb != 0) begin
                    if (LOCK_MAX > 1) begin m_locked = 1; m_owner = winner; m_cnt = 1; end
                    else m_to_pending = 1;
                end
            end else if (lb == 0) begin
                m_locked = 0; m_cnt = 0;
            end else if (m_cnt + 1 < LOCK_MAX) begin
                m_cnt++;
            end else begin
                m_locked = 0; m_cnt = 0; m_to_pending = 1;
            end
        end else if (out_rdy) begin
            m_occ = 0;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b1;
        in0_vld = 1'b0;
        in1_vld = 1'b0;
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_timeout", 64'(lock_timeout), 64'd0);
        sb_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: the front of the queue must be on out_* whenever out_vld; pop on handshake.
    initial begin
        beat_t exp_b;
        forever begin
            @(negedge clk);
            #2;
            if (out_vld && !rst) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: out_vld=1 got addr %0h, expected none", ob.addr);
                end else begin
                    exp_b = sb_q[0];
                    checks++;
                    if (ob !== exp_b) begin
                        errors++;
                        $display("FAIL beat: got src %0h addr %0h sb %0h data %0h, expected src %0h addr %0h sb %0h data %0h",
                                 ob.src, ob.addr, ob.sb, ob.data, exp_b.src, exp_b.addr, exp_b.sb, exp_b.data);
                    end
                    if (out_rdy) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_out_vld", 64'(out_vld), 64'd0);
        check("reset_payload", 64'(|ob), 64'd0);
        check("reset_timeout", 64'(lock_timeout), 64'd0);
        check("reset_in0_rdy", 64'(in0_rdy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) step(70, 25, 75);
        // Sustained contention with lock always requested: forced releases every LOCK_MAX beats.
        for (int i = 0; i < 60; i++) step(100, 100, 100);
        mid_reset();
        for (int i = 0; i < 200; i++) step(80, 70, 60);
        for (int i = 0; i < 20; i++) step(100, 100, 100);
        mid_reset();
        for (int i = 0; i < 150; i++) step(60, 40, 70);
        for (int i = 0; i < 6; i++) step(0, 0, 100);
        check("queue_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
